mac_accumulator: RTL
====================

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, the signed operand width.
REQ-002 The block SHALL have parameter ACC_W, default 40, the signed accumulator width; ACC_W SHALL be at least 2*DATA_W.
REQ-003 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port sel, input, 1 bit: phase from the upstream controller; 0 = INIT (first product of a group), 1 = POSE (accumulate).
REQ-006 Port in_valid, input, 1 bit: a, b and sel are valid this cycle.
REQ-007 Port a, input, DATA_W bits: signed operand A.
REQ-008 Port b, input, DATA_W bits: signed operand B.
REQ-009 Port flush, input, 1 bit: close the open group and emit it.
REQ-010 Port result, output, ACC_W bits: signed group sum; holds its value between emissions.
REQ-011 Port result_valid, output, 1 bit: one-cycle pulse, result/result_sat/result_count are new.
REQ-012 Port result_sat, output, 1 bit: the emitted group saturated at least once.
REQ-013 Port result_count, output, 8 bits: number of products in the emitted group, saturating at 255.

Function
REQ-014 Stage 1 SHALL register p = a*b (signed, full 2*DATA_W, sign-extended to ACC_W), along with sel and in_valid, as p_q, sel_q and vld_q.
REQ-015 Stage 2 SHALL hold acc (ACC_W), active (1 bit), sat (1 bit) and cnt (8 bits).
REQ-016 When vld_q=1 and sel_q=0 and active=1, the block SHALL emit acc/sat/cnt, then load acc=p_q, sat=0, cnt=1, and keep active=1.
REQ-017 When vld_q=1 and sel_q=0 and active=0, the block SHALL load acc=p_q, sat=0, cnt=1, set active=1, and not emit.
REQ-018 When vld_q=1 and sel_q=1 and active=1, the block SHALL set acc = sat-clamp(acc+p_q) and increment cnt, saturating at 255.
REQ-019 When vld_q=1 and sel_q=1 and active=0 (POSE with no prior INIT), the block SHALL treat the cycle as INIT (REQ-017).
REQ-020 Clamp: a sum above 2^(ACC_W-1)-1 or below -2^(ACC_W-1) SHALL clamp to that bound and set sat=1, which stays sticky until the next group load.
REQ-021 flush=1 with vld_q=0 and active=1 SHALL emit acc/sat/cnt and clear active.
REQ-022 flush=1 with active=0 and vld_q=0 SHALL have no effect.
REQ-023 flush=1 coincident with vld_q=1, sel_q=1 and active=1 SHALL accumulate first, emit the updated values, and clear active.
REQ-024 flush=1 coincident with vld_q=1 and sel_q=0 SHALL be ignored; REQ-016 or REQ-017 applies.
REQ-025 On emission, result, result_sat and result_count SHALL be registered, and result_valid SHALL be 1 for exactly the following cycle.
REQ-026 Latency: an INIT beat presented at edge t SHALL produce the closing result_valid at edge t+2; flush applied at edge t SHALL produce result_valid at t+1.
REQ-027 Cycles with vld_q=0 SHALL leave acc, cnt, sat and active unchanged (bubbles allowed mid-group).

Reset
REQ-028 rst=0 SHALL immediately clear p_q, sel_q, vld_q, acc, active, sat, cnt, result, result_valid, result_sat and result_count to 0, independent of clk.
REQ-029 Reset asserted mid-group SHALL discard the group with no emission; the first valid beat after release SHALL follow REQ-017 or REQ-019.

Verification
REQ-030 Group of 8 beats: sel=0 then seven beats with sel=1, a=3, b=-2, then an INIT beat -> result=-48, result_count=8, result_sat=0, one-cycle result_valid two edges after the INIT beat.
REQ-031 Bubbles: the same 8 products interleaved with in_valid=0 cycles -> identical result -48 and count 8.
REQ-032 DATA_W=8, ACC_W=20: 33 beats of a=127, b=127 then flush -> result=524287, result_sat=1, result_count=33.
REQ-033 Flush coincident with the final POSE beat (a=5, b=5, four beats) -> result=100, count=4; a second flush -> no result_valid.
REQ-034 Leading POSE without INIT (sel=1 first, a=2, b=2, three beats, flush) -> result=12, count=3.
REQ-035 rst pulsed low mid-group after 3 beats, then 2 beats of a=1, b=1 and flush -> outputs 0 during reset; then result=2, count=2, and no emission for the aborted group.

Source files
------------

// File: rtl/mac_accumulator.sv
// Two-stage signed multiply-accumulate: products are registered, then summed per
// group (INIT opens, POSE adds) with saturation, sticky overflow flag and count.
module mac_accumulator #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 40
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sel,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   input  logic                     flush,
   output logic signed [ACC_W-1:0]  result,
   output logic                     result_valid,
   output logic                     result_sat,
   output logic [7:0]               result_count
);

   localparam int PROD_W = 2 * DATA_W;

   typedef enum logic [0:0] {
      GRP_IDLE = 1'b0,
      GRP_OPEN = 1'b1
   } grp_state_t;

   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [7:0]       CNT_MAX = 8'd255;
   localparam logic [7:0]       CNT_ONE = 8'd1;

   // Saturating signed add; the top bit of the return value flags a clamp.
   function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] x,
                                              input logic [ACC_W-1:0] y);
      logic [ACC_W:0] sum;
      logic [ACC_W:0] res;
      sum = {x[ACC_W-1], x} + {y[ACC_W-1], y};
      if (sum[ACC_W] != sum[ACC_W-1]) begin
         res = sum[ACC_W] ? {1'b1, ACC_MIN} : {1'b1, ACC_MAX};
      end else begin
         res = {1'b0, sum[ACC_W-1:0]};
      end
      return res;
   endfunction

   logic signed [PROD_W-1:0] prod_s;
   logic [ACC_W-1:0]         p_q_r;
   logic                     sel_q_r;
   logic                     vld_q_r;

   grp_state_t               state_r;
   grp_state_t               state_nxt_s;
   logic [ACC_W-1:0]         acc_r;
   logic [ACC_W-1:0]         acc_nxt_s;
   logic                     sat_r;
   logic                     sat_nxt_s;
   logic [7:0]               cnt_r;
   logic [7:0]               cnt_nxt_s;

   logic [ACC_W:0]           add_s;
   logic [7:0]               cnt_inc_s;
   logic                     emit_s;
   logic [ACC_W-1:0]         emit_acc_s;
   logic                     emit_sat_s;
   logic [7:0]               emit_cnt_s;

   assign prod_s    = PROD_W'(a) * PROD_W'(b);
   assign add_s     = sat_add(acc_r, p_q_r);
   assign cnt_inc_s = (cnt_r == CNT_MAX) ? CNT_MAX : cnt_r + CNT_ONE;

   // Stage 1: product, phase and valid register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_q_r   <= {ACC_W{1'b0}};
         sel_q_r <= 1'b0;
         vld_q_r <= 1'b0;
      end else begin
         p_q_r   <= ACC_W'(prod_s);
         sel_q_r <= sel;
         vld_q_r <= in_valid;
      end
   end

   // Stage 2 group control; a POSE arriving with no open group is handled as INIT.
   always_comb begin
      state_nxt_s = state_r;
      acc_nxt_s   = acc_r;
      sat_nxt_s   = sat_r;
      cnt_nxt_s   = cnt_r;
      emit_s      = 1'b0;
      emit_acc_s  = acc_r;
      emit_sat_s  = sat_r;
      emit_cnt_s  = cnt_r;
      case (state_r)
         GRP_OPEN: begin
            if (vld_q_r && sel_q_r) begin
               acc_nxt_s = add_s[ACC_W-1:0];
               sat_nxt_s = sat_r | add_s[ACC_W];
               cnt_nxt_s = cnt_inc_s;
               if (flush) begin
                  emit_s      = 1'b1;
                  emit_acc_s  = add_s[ACC_W-1:0];
                  emit_sat_s  = sat_r | add_s[ACC_W];
                  emit_cnt_s  = cnt_inc_s;
                  state_nxt_s = GRP_IDLE;
               end else begin
                  state_nxt_s = GRP_OPEN;
               end
            end else if (vld_q_r) begin
               emit_s      = 1'b1;
               acc_nxt_s   = p_q_r;
               sat_nxt_s   = 1'b0;
               cnt_nxt_s   = CNT_ONE;
               state_nxt_s = GRP_OPEN;
            end else if (flush) begin
               emit_s      = 1'b1;
               state_nxt_s = GRP_IDLE;
            end else begin
               state_nxt_s = GRP_OPEN;
            end
         end
         GRP_IDLE: begin
            if (vld_q_r) begin
               acc_nxt_s   = p_q_r;
               sat_nxt_s   = 1'b0;
               cnt_nxt_s   = CNT_ONE;
               state_nxt_s = GRP_OPEN;
            end else begin
               state_nxt_s = GRP_IDLE;
            end
         end
         default: begin
            state_nxt_s = GRP_IDLE;
         end
      endcase
   end

   // Stage 2 accumulator state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= GRP_IDLE;
         acc_r   <= {ACC_W{1'b0}};
         sat_r   <= 1'b0;
         cnt_r   <= 8'd0;
      end else begin
         state_r <= state_nxt_s;
         acc_r   <= acc_nxt_s;
         sat_r   <= sat_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Result registers hold between emissions; valid pulses for one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         result       <= {ACC_W{1'b0}};
         result_valid <= 1'b0;
         result_sat   <= 1'b0;
         result_count <= 8'd0;
      end else if (emit_s) begin
         result       <= emit_acc_s;
         result_valid <= 1'b1;
         result_sat   <= emit_sat_s;
         result_count <= emit_cnt_s;
      end else begin
         result_valid <= 1'b0;
      end
   end

endmodule
